dilithium_job_arbiter: RTL

- Shares one dilithium core between N_REQ requesters.
- Arbitrates job requests round-robin and resets the core between jobs.
- Issues the start pulse and mode, and routes the granted requester's input and output streams to and from the core.
- Ends a job after a per-mode count of core output words, then frees the core for the next requester.

---
 rtl/dilithium_job_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dilithium_job_arbiter.sv
// rtl/dilithium_job_arbiter.sv - round-robin job arbiter sharing one dilithium core
module dilithium_job_arbiter #(
    parameter int W            = 64,
    parameter int N_REQ        = 2,
    parameter int RST_CYCLES   = 4,
    parameter int OUT_WORDS_M0 = 1,
    parameter int OUT_WORDS_M1 = 1,
    parameter int OUT_WORDS_M2 = 1,
    parameter int CTR_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [2*N_REQ-1:0] req_mode_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   job_done_o,
    output logic [N_REQ-1:0]   job_err_o,
    output logic               busy_o,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [W*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   rsp_valid_o,
    output logic [W-1:0]       rsp_data_o,
    input  logic [N_REQ-1:0]   rsp_ready_i,
    output logic               core_rst,
    output logic               core_start,
    output logic [1:0]         core_mode,
    output logic               core_valid_i,
    input  logic               core_ready_i,
    output logic [W-1:0]       core_data_i,
    input  logic               core_valid_o,
    output logic               core_ready_o,
    input  logic [W-1:0]       core_data_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = IW + 1;
    localparam int RW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REJECT, CORE_RST, START, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    g, g_n, rr, rr_n, pick, g_inc;
    logic [CW-1:0]    cand;
    logic             found;
    logic [1:0]       mode, mode_n;
    logic [N_REQ-1:0] gnt, gnt_n, g_oh;
    logic [RW-1:0]    rcnt, rcnt_n;
    logic [CTR_W-1:0] ocnt, ocnt_n, last_cnt;
    logic             out_hs;

    // First requester at or above rr, wrapping; cand never exceeds N_REQ-1 after the fold.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr} + CW'(i);
            if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
            if (!found && req_i[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        g_oh    = '0;
        g_oh[g] = 1'b1;
    end

    always_comb begin
        case (mode)
            2'd0:    last_cnt = CTR_W'(OUT_WORDS_M0 - 1);
            2'd1:    last_cnt = CTR_W'(OUT_WORDS_M1 - 1);
            2'd2:    last_cnt = CTR_W'(OUT_WORDS_M2 - 1);
            default: last_cnt = '0;
        endcase
    end

    assign g_inc  = (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
    assign out_hs = (state == RUN) && core_valid_o && rsp_ready_i[g];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            mode  <= '0;
            gnt   <= '0;
            rr    <= '0;
            rcnt  <= '0;
            ocnt  <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            mode  <= mode_n;
            gnt   <= gnt_n;
            rr    <= rr_n;
            rcnt  <= rcnt_n;
            ocnt  <= ocnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        g_n          = g;
        mode_n       = mode;
        gnt_n        = gnt;
        rr_n         = rr;
        rcnt_n       = rcnt;
        ocnt_n       = ocnt;
        gnt_o        = '0;
        job_done_o   = '0;
        job_err_o    = '0;
        busy_o       = 1'b0;
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        rsp_data_o   = '0;
        core_start   = 1'b0;
        core_mode    = 2'd0;
        core_valid_i = 1'b0;
        core_data_i  = '0;
        core_ready_o = 1'b0;
        core_rst     = rst || (state == CORE_RST);

        case (state)
            IDLE: if (found) begin
                g_n         = pick;
                mode_n      = req_mode_i[{pick, 1'b0} +: 2];
                gnt_n       = '0;
                gnt_n[pick] = 1'b1;
                state_n     = (mode_n == 2'd3) ? REJECT : CORE_RST;
            end
            REJECT: begin
                gnt_n   = '0;
                rr_n    = g_inc;
                state_n = IDLE;
            end
            CORE_RST: begin
                if (rcnt == RW'(RST_CYCLES - 1)) begin
                    rcnt_n  = '0;
                    state_n = START;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            START: state_n = RUN;
            RUN: if (out_hs) begin
                ocnt_n = ocnt + 1'b1;
                if (ocnt == last_cnt) state_n = DONE;
            end
            DONE: begin
                gnt_n   = '0;
                ocnt_n  = '0;
                rr_n    = g_inc;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are forced quiet while rst is high so an aborted job leaves no trace.
        if (!rst) begin
            gnt_o  = gnt;
            busy_o = (state != IDLE);
            if (state inside {CORE_RST, START, RUN, DONE}) core_mode = mode;
            case (state)
                REJECT: job_err_o  = g_oh;
                START:  core_start = 1'b1;
                DONE:   job_done_o = g_oh;
                RUN: begin
                    core_valid_i = req_valid_i[g];
                    core_data_i  = req_data_i[g*W +: W];
                    req_ready_o  = core_ready_i ? g_oh : '0;
                    rsp_valid_o  = core_valid_o ? g_oh : '0;
                    rsp_data_o   = core_data_o;
                    core_ready_o = rsp_ready_i[g];
                end
                default: ;
            endcase
        end
    end
endmodule
